mem_stage: RTL

//  Memory-access stage directly downstream of the EX/MEM pipeline register. Takes the ALU

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_align.sv | 45 ++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, byte-enable patterns
// and the width of the bus-timeout counter.
package mem_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_align.sv
// Byte/word steering for the data bus: store-side byte enables and lane replication,
// load-side lane select with zero extension.
module mem_align
    import mem_defs::*;
(
    input  logic [1:0]  i_st_lane,
    input  logic        i_st_word,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_lane,
    input  logic        i_ld_word,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_st_data;
        if (!i_st_word) begin
            o_wdata = {4{i_st_data[7:0]}};
            unique case (i_st_lane)
                2'd0:    o_be = BE_BYTE0;
                2'd1:    o_be = BE_BYTE1;
                2'd2:    o_be = BE_BYTE2;
                default: o_be = BE_BYTE3;
            endcase
        end
    end

    always_comb begin
        o_load_data = i_rdata;
        if (!i_ld_word) begin
            unique case (i_ld_lane)
                2'd0:    o_load_data = {24'd0, i_rdata[7:0]};
                2'd1:    o_load_data = {24'd0, i_rdata[15:8]};
                2'd2:    o_load_data = {24'd0, i_rdata[23:16]};
                default: o_load_data = {24'd0, i_rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory transaction with timeout, upstream
// stall, and the MEM/WB register. Define MEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module mem_stage
    import mem_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_word,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic [31:0] in_result,
    input  logic [31:0] in_write_data,
    input  logic [4:0]  in_rd,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_reg_write,
    output logic [4:0]  out_rd,
    output logic [31:0] out_wb_data,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_count;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [1:0]        r_lane;
    logic              r_word;
    logic [31:0]       r_data;
    logic              r_err;
    logic              r_bus_err;
    logic              r_reg_write;
    logic [4:0]        r_rd;
    logic [31:0]       r_wb_data;

    logic              w_access;
    logic              w_misalign;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_data;

    assign w_access  = in_mem_read | in_mem_write;
    assign w_timeout = (r_count == LP_CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = in_word & (in_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    mem_align u_align (
        .i_st_lane   (in_result[1:0]),
        .i_st_word   (in_word),
        .i_st_data   (in_write_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_lane   (r_lane),
        .i_ld_word   (r_word),
        .i_rdata     (dmem_rdata),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    stall  = 1'b1;
                    w_next = w_misalign ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (dmem_ack || w_timeout) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    // NOTE: all registers here are flops (no memory arrays), so all take the async reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_lane      <= '0;
            r_word      <= 1'b0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_bus_err   <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wb_data   <= '0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_count <= '0;
                        r_lane  <= in_result[1:0];
                        r_word  <= in_word;
                        if (w_misalign) begin
                            r_err     <= 1'b1;
                            r_bus_err <= 1'b1;
                            r_data    <= '0;
                        end else begin
                            r_err   <= 1'b0;
                            r_req   <= 1'b1;
                            r_we    <= in_mem_write;
                            r_addr  <= {in_result[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                        end
                    end else begin
                        r_wb_data   <= in_result;
                        r_rd        <= in_rd;
                        r_reg_write <= in_reg_write;
                    end
                end
                ST_BUSY: begin
                    // An ack on the last counted cycle still wins over the timeout.
                    if (dmem_ack) begin
                        r_req  <= 1'b0;
                        r_data <= w_load_data;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_data    <= '0;
                        r_err     <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    // EX/MEM still holds the same instruction during DONE.
                    r_wb_data   <= in_mem_to_reg ? r_data : in_result;
                    r_rd        <= in_rd;
                    r_reg_write <= in_reg_write & ~in_mem_write & ~r_err;
                end
            endcase
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign dmem_be       = r_be;
    assign bus_err       = r_bus_err;
    assign out_reg_write = r_reg_write;
    assign out_rd        = r_rd;
    assign out_wb_data   = r_wb_data;

endmodule
